// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART byte-stream frame decoder (HEADER,CMD,DATA,CSUM) driving seg/PWM/LED registers
// Optional inter-byte timeout abort is compiled in with PARSER_TIMEOUT_EN.
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER         = 8'hAA,
  parameter int          PWM_MAX        = 100,
  parameter int          TIMEOUT_CYCLES = 104160,
  parameter logic [15:0] SEG_RST        = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] seg_value,
  output logic [7:0]  pwm_duty,
  output logic [7:0]  led_mask,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_GET_CMD  = 2'd1;
  localparam logic [1:0] S_GET_DATA = 2'd2;
  localparam logic [1:0] S_GET_CSUM = 2'd3;

  localparam logic [7:0] PWM_MAX_B = 8'(PWM_MAX);

  logic [1:0] r_state;
  logic [7:0] r_cmd;
  logic [7:0] r_data;
  logic       w_timeout;
  logic       w_csum_ok;

  assign w_csum_ok = (rx_data == (r_cmd ^ r_data));

`ifdef PARSER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tmo_cnt;

  assign w_timeout = (r_state != S_IDLE) && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_IDLE) || rx_valid || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cmd     <= 8'h00;
      r_data    <= 8'h00;
      seg_value <= SEG_RST;
      pwm_duty  <= 8'h00;
      led_mask  <= 8'h00;
      cmd_ok    <= 1'b0;
      cmd_err   <= 1'b0;
      err_code  <= 2'd0;
      frame_cnt <= 8'h00;
    end else begin
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;
      // An expiring timeout beats a byte arriving in the same cycle; that byte is dropped.
      if (w_timeout) begin
        r_state  <= S_IDLE;
        cmd_err  <= 1'b1;
        err_code <= 2'd3;
      end else if (rx_valid) begin
        case (r_state)
          S_IDLE: begin
            if (rx_data == HEADER) r_state <= S_GET_CMD;
          end
          S_GET_CMD: begin
            r_cmd   <= rx_data;
            r_state <= S_GET_DATA;
          end
          S_GET_DATA: begin
            r_data  <= rx_data;
            r_state <= S_GET_CSUM;
          end
          default: begin
            r_state <= S_IDLE;
            if (!w_csum_ok) begin
              cmd_err  <= 1'b1;
              err_code <= 2'd1;
            end else begin
              case (r_cmd)
                8'h01: seg_value[7:0]  <= r_data;
                8'h02: seg_value[15:8] <= r_data;
                8'h03: pwm_duty        <= (r_data > PWM_MAX_B) ? PWM_MAX_B : r_data;
                8'h04: led_mask        <= r_data;
                8'h05: begin
                  seg_value <= SEG_RST;
                  pwm_duty  <= 8'h00;
                  led_mask  <= 8'h00;
                end
                default: ;
              endcase
              if ((r_cmd >= 8'h01) && (r_cmd <= 8'h05)) begin
                cmd_ok    <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
              end else begin
                cmd_err  <= 1'b1;
                err_code <= 2'd2;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - table-driven, scoreboarded bench for uart_cmd_parser
module tb_uart_cmd_parser;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] seg_value;
  logic [7:0]  pwm_duty;
  logic [7:0]  led_mask;
  logic        cmd_ok;
  logic        cmd_err;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;

  uart_cmd_parser #(
    .HEADER(8'hAA), .PWM_MAX(100), .TIMEOUT_CYCLES(50), .SEG_RST(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .seg_value(seg_value), .pwm_duty(pwm_duty), .led_mask(led_mask),
    .cmd_ok(cmd_ok), .cmd_err(cmd_err), .err_code(err_code), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ok;
    logic [1:0]  ec;
    logic [15:0] seg;
    logic [7:0]  pwm;
    logic [7:0]  led;
    logic [7:0]  fc;
  } exp_t;

  typedef struct {
    logic [31:0] bytes;
    logic        ok;
    logic [1:0]  ec;
    logic [15:0] seg;
    logic [7:0]  pwm;
    logic [7:0]  led;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] exp_fc = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic ok, input logic [1:0] ec, input logic [15:0] seg,
                              input logic [7:0] pwm, input logic [7:0] led);
    exp_t e;
    if (ok) exp_fc = exp_fc + 8'd1;
    e.ok = ok; e.ec = ec; e.seg = seg; e.pwm = pwm; e.led = led; e.fc = exp_fc;
    sb.push_back(e);
  endtask

  // Bytes are MSB-first in 'bytes'; called and returning on a negedge.
  task automatic send(input logic [63:0] bytes, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      rx_data  = bytes[8*(n-1-i) +: 8];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      if (i != n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (cmd_ok || cmd_err)) begin
      chk("ok_err_exclusive", {31'd0, cmd_ok & cmd_err}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, cmd_ok, cmd_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cmd_ok", {31'd0, cmd_ok}, {31'd0, e.ok});
        chk("cmd_err", {31'd0, cmd_err}, {31'd0, ~e.ok});
        if (!e.ok) chk("err_code", {30'd0, err_code}, {30'd0, e.ec});
        chk("seg_value", {16'd0, seg_value}, {16'd0, e.seg});
        chk("pwm_duty", {24'd0, pwm_duty}, {24'd0, e.pwm});
        chk("led_mask", {24'd0, led_mask}, {24'd0, e.led});
        chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, e.fc});
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"}, {16'd0, seg_value}, 32'h0);
    chk({tag, "_pwm"}, {24'd0, pwm_duty}, 32'h0);
    chk({tag, "_led"}, {24'd0, led_mask}, 32'h0);
    chk({tag, "_pulses"}, {30'd0, cmd_ok, cmd_err}, 32'h0);
    chk({tag, "_ec"}, {30'd0, err_code}, 32'h0);
    chk({tag, "_fc"}, {24'd0, frame_cnt}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[12];
    int   seen_at;

    vt[0]  = '{32'hAA033231, 1'b1, 2'd0, 16'h0000, 8'h32, 8'h00};
    vt[1]  = '{32'hAA013435, 1'b1, 2'd0, 16'h0034, 8'h32, 8'h00};
    vt[2]  = '{32'hAA021210, 1'b1, 2'd0, 16'h1234, 8'h32, 8'h00};
    vt[3]  = '{32'hAA03C8CB, 1'b1, 2'd0, 16'h1234, 8'h64, 8'h00};
    vt[4]  = '{32'hAA040F0B, 1'b1, 2'd0, 16'h1234, 8'h64, 8'h0F};
    vt[5]  = '{32'hAA04FF00, 1'b0, 2'd1, 16'h1234, 8'h64, 8'h0F};
    vt[6]  = '{32'hAA070106, 1'b0, 2'd2, 16'h1234, 8'h64, 8'h0F};
    vt[7]  = '{32'hAA036467, 1'b1, 2'd0, 16'h1234, 8'h64, 8'h0F};
    vt[8]  = '{32'hAA030102, 1'b1, 2'd0, 16'h1234, 8'h01, 8'h0F};
    vt[9]  = '{32'hAA036566, 1'b1, 2'd0, 16'h1234, 8'h64, 8'h0F};
    vt[10] = '{32'hAAAA01AB, 1'b0, 2'd2, 16'h1234, 8'h64, 8'h0F};
    vt[11] = '{32'hAA050005, 1'b1, 2'd0, 16'h0000, 8'h00, 8'h00};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      expect_frame(vt[i].ok, vt[i].ec, vt[i].seg, vt[i].pwm, vt[i].led);
      send({32'd0, vt[i].bytes}, 4, i % 3);
      chk("latency", {31'd0, cmd_ok | cmd_err}, 32'd1);
      repeat (i % 2) @(negedge clk);
    end

    // Garbage ahead of a frame, all bytes on consecutive cycles.
    expect_frame(1'b1, 2'd0, 16'h0000, 8'h00, 8'hA5);
    send(64'h5513AA04A5A1, 6, 0);
    chk("garbage_latency", {31'd0, cmd_ok}, 32'd1);
    repeat (3) @(negedge clk);

    // Stalled frame: aborts with err_code 3 when the timeout is built in, else completes.
`ifdef PARSER_TIMEOUT_EN
    expect_frame(1'b0, 2'd3, 16'h0000, 8'h00, 8'hA5);
`endif
    send(64'hAA04, 2, 0);
    seen_at = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (cmd_err && seen_at == 0) seen_at = k;
    end
`ifdef PARSER_TIMEOUT_EN
    chk("timeout_cycle", seen_at, 32'd50);
`else
    chk("no_timeout", seen_at, 32'd0);
    expect_frame(1'b1, 2'd0, 16'h0000, 8'h00, 8'h3C);
`endif
    send(64'h3C38, 2, 0);
    repeat (3) @(negedge clk);
`ifdef PARSER_TIMEOUT_EN
    chk("trailing_ignored_led", {24'd0, led_mask}, 32'hA5);
`else
    chk("stall_complete_led", {24'd0, led_mask}, 32'h3C);
`endif

    // Reset in the middle of a frame.
    send(64'hAA03, 2, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midreset");
    rst_n = 1'b1;
    exp_fc = 8'h00;
    send(64'h3231, 2, 0);
    repeat (3) @(negedge clk);
    chk("post_reset_pwm", {24'd0, pwm_duty}, 32'h0);
    expect_frame(1'b1, 2'd0, 16'h0077, 8'h00, 8'h00);
    send(64'hAA017776, 4, 1);
    chk("post_reset_latency", {31'd0, cmd_ok}, 32'd1);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
